// File: rtl/vector_elemwise_pipe_if.sv
// rtl/vector_elemwise_pipe_if.sv - stream bundle for the vector elementwise pipe
// Purpose: carries the operand beat stream into the pipe and the result beat
//          stream out of it.
// Signals: in0/in1     operand vectors, lane i at [i*bitwidth +: bitwidth]
//          in_mode     0=MUL 1=ADD 2=MAC 3=MUL, sampled on the first packet beat
//          in_valid/in_ready/in_last     input beat handshake and packet end
//          out/out_sat                   result vector and per-lane clamp flags
//          out_valid/out_ready/out_last  output beat handshake and packet end
// Modports: master = beat source / result sink, slave = the pipe itself.
interface vector_elemwise_pipe_if #(
   parameter int bitwidth = 16,
   parameter int N        = 8
);
   logic [N*bitwidth-1:0] in0;
   logic [N*bitwidth-1:0] in1;
   logic [1:0]            in_mode;
   logic                  in_valid;
   logic                  in_last;
   logic                  in_ready;
   logic [N*bitwidth-1:0] out;
   logic [N-1:0]          out_sat;
   logic                  out_valid;
   logic                  out_last;
   logic                  out_ready;

   modport master (
      output in0, in1, in_mode, in_valid, in_last, out_ready,
      input  in_ready, out, out_sat, out_valid, out_last
   );

   modport slave (
      input  in0, in1, in_mode, in_valid, in_last, out_ready,
      output in_ready, out, out_sat, out_valid, out_last
   );
endinterface

// File: rtl/vector_elemwise_pipe.sv
// rtl/vector_elemwise_pipe.sv - N-lane signed fixed-point MUL/ADD/MAC pipeline
// Purpose: two-stage vector ALU. Stage 1 forms full-precision per-lane product
//          and sum; stage 2 rounds, saturates and (in MAC mode) accumulates
//          over a packet, emitting a single vector on the last beat.
// Ports:   clk   rising-edge clock
//          rstn  asynchronous active-low reset
//          bus   vector_elemwise_pipe_if.slave (operand and result streams)
module vector_elemwise_pipe #(
   parameter int bitwidth = 16,
   parameter int N        = 8,
   parameter int FRAC     = 8,
   parameter int ACCW     = 2*bitwidth+8
) (
   input  logic                 clk,
   input  logic                 rstn,
   vector_elemwise_pipe_if.slave bus
);
   localparam logic [1:0] MODE_MUL = 2'd0;
   localparam logic [1:0] MODE_ADD = 2'd1;
   localparam logic [1:0] MODE_MAC = 2'd2;
   localparam int PW = 2*bitwidth;
   localparam int SW = bitwidth+1;
   // One guard bit above the accumulator so the rounding add cannot wrap.
   localparam int RW = ACCW+1;

   localparam logic signed [RW-1:0] HALF = (RW'(1) << FRAC) >> 1;
   localparam logic signed [RW-1:0] MAXW = {{(RW-bitwidth+1){1'b0}}, {(bitwidth-1){1'b1}}};
   localparam logic signed [RW-1:0] MINW = {{(RW-bitwidth+1){1'b1}}, {(bitwidth-1){1'b0}}};

   logic                  en;
   logic                  accept;
   logic                  start_q;
   logic [1:0]            mode_q;
   logic [1:0]            cur_mode;

   logic                  s1_valid;
   logic                  s1_last;
   logic [1:0]            s1_mode;
   logic signed [PW-1:0]  s1_p [N];
   logic signed [SW-1:0]  s1_s [N];

   logic signed [ACCW-1:0] acc     [N];
   logic signed [ACCW-1:0] acc_sum [N];
   logic [bitwidth-1:0]    res     [N];
   logic [N-1:0]           clamp;
   logic                   emit;

   logic                  out_valid_q;
   logic                  out_last_q;
   logic [N*bitwidth-1:0] out_q;
   logic [N-1:0]          out_sat_q;

   // The whole pipe moves as one; a stalled output freezes every stage.
   assign en            = !out_valid_q || bus.out_ready;
   assign bus.in_ready  = en;
   assign accept        = bus.in_valid && en;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.out       = out_q;
   assign bus.out_sat   = out_sat_q;

   // Mode for the beat being presented: fresh on a packet's first beat,
   // latched afterwards. The reserved code folds onto MUL here so later
   // stages only ever see three modes.
   always_comb begin
      cur_mode = start_q ? bus.in_mode : mode_q;
      if (cur_mode == 2'd3) begin
         cur_mode = MODE_MUL;
      end
   end

   // MAC beats that are not the packet end only update the accumulator.
   assign emit = s1_valid && !(s1_mode == MODE_MAC && !s1_last);

   always_comb begin
      logic signed [ACCW-1:0] src;
      logic signed [RW-1:0]   wide;
      src   = '0;
      wide  = '0;
      clamp = '0;
      for (int i = 0; i < N; i++) begin
         acc_sum[i] = acc[i] + ACCW'(s1_p[i]);
         src        = (s1_mode == MODE_MAC) ? acc_sum[i] : ACCW'(s1_p[i]);
         // Round half up, then floor via arithmetic shift.
         wide       = (RW'(src) + HALF) >>> FRAC;
         if (s1_mode == MODE_ADD) begin
            wide = RW'(s1_s[i]);
         end
         res[i] = wide[bitwidth-1:0];
         if (wide > MAXW) begin
            res[i]   = MAXW[bitwidth-1:0];
            clamp[i] = 1'b1;
         end else if (wide < MINW) begin
            res[i]   = MINW[bitwidth-1:0];
            clamp[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         start_q     <= 1'b1;
         mode_q      <= MODE_MUL;
         s1_valid    <= 1'b0;
         s1_last     <= 1'b0;
         s1_mode     <= MODE_MUL;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_q       <= '0;
         out_sat_q   <= '0;
         for (int i = 0; i < N; i++) begin
            s1_p[i] <= '0;
            s1_s[i] <= '0;
            acc[i]  <= '0;
         end
      end else if (en) begin
         if (accept) begin
            if (start_q) begin
               mode_q <= cur_mode;
            end
            start_q <= bus.in_last;
         end

         s1_valid <= bus.in_valid;
         s1_last  <= bus.in_last;
         s1_mode  <= cur_mode;
         for (int i = 0; i < N; i++) begin
            s1_p[i] <= PW'(signed'(bus.in0[i*bitwidth +: bitwidth]))
                     * PW'(signed'(bus.in1[i*bitwidth +: bitwidth]));
            s1_s[i] <= SW'(signed'(bus.in0[i*bitwidth +: bitwidth]))
                     + SW'(signed'(bus.in1[i*bitwidth +: bitwidth]));
         end

         if (s1_valid && s1_mode == MODE_MAC) begin
            for (int i = 0; i < N; i++) begin
               acc[i] <= s1_last ? '0 : acc_sum[i];
            end
         end

         out_valid_q <= emit;
         if (emit) begin
            out_last_q <= s1_last;
            out_sat_q  <= clamp;
            for (int i = 0; i < N; i++) begin
               out_q[i*bitwidth +: bitwidth] <= res[i];
            end
         end
      end
   end
endmodule

// File: tb/tb_vector_elemwise_pipe.sv
// tb/tb_vector_elemwise_pipe.sv - self-checking bench for vector_elemwise_pipe
module tb_vector_elemwise_pipe;
   localparam int BW   = 16;
   localparam int N    = 4;
   localparam int FRAC = 8;
   localparam int ACCW = 2*BW+8;

   typedef struct {
      logic [N*BW-1:0] data;
      logic [N-1:0]    sat;
      logic            last;
   } exp_t;

   typedef struct {
      logic [N*BW-1:0] a;
      logic [N*BW-1:0] b;
      logic [1:0]      mode;
      logic [N*BW-1:0] exp_data;
      logic [N-1:0]    exp_sat;
   } vec_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   vector_elemwise_pipe_if #(.bitwidth(BW), .N(N)) bus();

   vector_elemwise_pipe #(.bitwidth(BW), .N(N), .FRAC(FRAC), .ACCW(ACCW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int     n_checks = 0;
   int     n_fail   = 0;
   int     cyc      = 0;
   int     drive_cyc = 0;
   int     out_cyc   = 0;
   bit     rand_ready = 0;
   exp_t   exp_q [$];
   string  tname = "reset";

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s.%s: got %h expected %h", tname, name, act, req);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
   end

   // Output monitor: scoreboard compare on every handshake, stability and
   // in_ready checks on every stalled cycle.
   initial begin
      bit   held = 0;
      exp_t hv;
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rstn) begin
            held = 0;
         end else begin
            if (held) begin
               check("hold_valid", bus.out_valid, 1);
               check("hold_data", bus.out, hv.data);
               check("hold_sat", bus.out_sat, hv.sat);
               check("hold_last", bus.out_last, hv.last);
            end
            held = 0;
            if (bus.out_valid && !bus.out_ready) begin
               held = 1;
               hv.data = bus.out;
               hv.sat  = bus.out_sat;
               hv.last = bus.out_last;
               check("stall_in_ready", bus.in_ready, 0);
            end else if (bus.out_valid) begin
               out_cyc = cyc;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL %s.unexpected_output: got %h expected no beat", tname, bus.out);
               end else begin
                  e = exp_q.pop_front();
                  check("data", bus.out, e.data);
                  check("sat", bus.out_sat, e.sat);
                  check("last", bus.out_last, e.last);
               end
            end
         end
      end
   end

   task automatic send_beat(input logic [N*BW-1:0] a, input logic [N*BW-1:0] b,
                            input logic [1:0] m, input logic last);
      int guard = 0;
      @(negedge clk);
      bus.in0 = a;
      bus.in1 = b;
      bus.in_mode = m;
      bus.in_last = last;
      bus.in_valid = 1'b1;
      #1;
      while (!bus.in_ready && guard < 200) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (guard >= 200) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s.in_ready_timeout: got 0 expected 1", tname);
      end
      drive_cyc = cyc;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while (exp_q.size() != 0 && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      check("drain_pending", exp_q.size(), 0);
      exp_q.delete();
      repeat (4) @(negedge clk);
   endtask

   function automatic void sat16(input longint v, output logic [15:0] r, output logic c);
      if (v > 32767) begin
         r = 16'h7FFF; c = 1'b1;
      end else if (v < -32768) begin
         r = 16'h8000; c = 1'b1;
      end else begin
         r = 16'(v); c = 1'b0;
      end
   endfunction

   function automatic exp_t mk(input logic [15:0] v, input logic last);
      exp_t e;
      e.data = {N{v}};
      e.sat  = '0;
      e.last = last;
      return e;
   endfunction

   vec_t tbl [5];

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.in0 = '0; bus.in1 = '0; bus.in_mode = 2'd0;
      bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;

      tbl[0] = '{{4{16'h0200}}, {4{16'h0180}}, 2'd0, {4{16'h0300}}, 4'b0000};
      tbl[1] = '{{16'hFFFF, 16'h0001, 16'h8100, 16'h7F00}, {16'h0080, 16'h0080, 16'h0200, 16'h0200},
                 2'd0, {16'h0000, 16'h0001, 16'h8000, 16'h7FFF}, 4'b0011};
      tbl[2] = '{{16'h1234, 16'h0100, 16'h9000, 16'h7000}, {16'h0000, 16'hFF00, 16'hE000, 16'h2000},
                 2'd1, {16'h1234, 16'h0000, 16'h8000, 16'h7FFF}, 4'b0011};
      tbl[3] = '{{16'hFE00, 16'h0080, 16'h0300, 16'h0200}, {16'h0180, 16'h0080, 16'hFF00, 16'h0180},
                 2'd3, {16'hFD00, 16'h0040, 16'hFD00, 16'h0300}, 4'b0000};
      tbl[4] = '{{16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF}, {16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF},
                 2'd1, {16'h8000, 16'h7FFF, 16'h0000, 16'hFFFE}, 4'b0000};

      #1;
      check("out_valid", bus.out_valid, 0);
      check("out", bus.out, 0);
      check("out_sat", bus.out_sat, 0);
      check("out_last", bus.out_last, 0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      #1;
      check("in_ready", bus.in_ready, 1);

      for (int i = 0; i < 5; i++) begin
         exp_t e;
         $sformat(tname, "table%0d", i);
         e.data = tbl[i].exp_data;
         e.sat  = tbl[i].exp_sat;
         e.last = 1'b1;
         exp_q.push_back(e);
         send_beat(tbl[i].a, tbl[i].b, tbl[i].mode, 1'b1);
         drain();
         check("latency", out_cyc - drive_cyc, 2);
      end

      tname = "mac";
      exp_q.push_back(mk(16'h0400, 1'b1));
      send_beat({4{16'h0100}}, {4{16'h0100}}, 2'd2, 1'b0);
      send_beat({4{16'h0100}}, {4{16'h0100}}, 2'd1, 1'b0);
      send_beat({4{16'h0100}}, {4{16'h0100}}, 2'd1, 1'b0);
      send_beat({4{16'h0100}}, {4{16'h0100}}, 2'd1, 1'b1);
      drain();
      exp_q.push_back(mk(16'h0300, 1'b1));
      send_beat({4{16'h0200}}, {4{16'h0180}}, 2'd0, 1'b1);
      exp_q.push_back(mk(16'h0200, 1'b1));
      send_beat({4{16'h0100}}, {4{16'h0200}}, 2'd2, 1'b1);
      drain();

      tname = "backpressure";
      for (int k = 1; k <= 10; k++) exp_q.push_back(mk(16'(k), k == 10));
      fork
         for (int k = 1; k <= 10; k++) send_beat({4{16'(k)}}, {4{16'h0100}}, 2'd0, k == 10);
         for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            bus.out_ready = !(c >= 3 && c <= 7);
         end
      join
      bus.out_ready = 1'b1;
      drain();

      tname = "reset_abort";
      send_beat({4{16'h0100}}, {4{16'h0100}}, 2'd2, 1'b0);
      send_beat({4{16'h0100}}, {4{16'h0100}}, 2'd2, 1'b0);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out", bus.out, 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      exp_q.push_back(mk(16'h0300, 1'b1));
      send_beat({4{16'h0100}}, {4{16'h0300}}, 2'd2, 1'b1);
      drain();

      tname = "random";
      rand_ready = 1;
      for (int pkt = 0; pkt < 40; pkt++) begin
         logic [1:0] m0;
         logic [1:0] eff;
         int         len;
         longint     acc [N];
         m0  = 2'($urandom_range(0, 3));
         eff = (m0 == 2'd3) ? 2'd0 : m0;
         len = $urandom_range(1, 4);
         for (int l = 0; l < N; l++) acc[l] = 0;
         for (int bt = 0; bt < len; bt++) begin
            logic [N*BW-1:0] a, b;
            exp_t e;
            bit   last;
            last = (bt == len - 1);
            for (int l = 0; l < N; l++) begin
               a[l*BW +: BW] = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
               b[l*BW +: BW] = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
            end
            e.last = last;
            e.sat  = '0;
            e.data = '0;
            for (int l = 0; l < N; l++) begin
               longint    va, vb, v;
               logic [15:0] r;
               logic        c;
               va = longint'($signed(a[l*BW +: BW]));
               vb = longint'($signed(b[l*BW +: BW]));
               if (eff == 2'd1) v = va + vb;
               else if (eff == 2'd0) v = (va * vb + 128) >>> FRAC;
               else begin
                  acc[l] = acc[l] + va * vb;
                  v = (acc[l] + 128) >>> FRAC;
               end
               sat16(v, r, c);
               e.data[l*BW +: BW] = r;
               e.sat[l] = c;
            end
            if (eff != 2'd2 || last) exp_q.push_back(e);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send_beat(a, b, (bt == 0) ? m0 : 2'($urandom_range(0, 3)), last);
         end
      end
      rand_ready = 0;
      @(negedge clk);
      bus.out_ready = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
